// File: rtl/calc_sequencer.sv
// Calculator entry sequencer: steps through operand digit entry, operation select,
// result display and register clear, issuing one-cycle store/clear strobes.
module calc_sequencer #(
    parameter int N_OPERANDS = 2,
    parameter int N_DIGITS   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            exe,
    input  logic                            button,
    input  logic                            clear,
    output logic [N_OPERANDS-1:0]           trigger,
    output logic                            trigger_op,
    output logic                            reset_a_reg,
    output logic [$clog2(N_OPERANDS+3)-1:0] estado,
    output logic [$clog2(N_DIGITS+1)-1:0]   digit_count,
    output logic                            full
);

    localparam int KW = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1;
    localparam int EW = $clog2(N_OPERANDS + 3);
    localparam int DW = $clog2(N_DIGITS + 1);

    localparam logic [KW-1:0] K_LAST   = KW'(N_OPERANDS - 1);
    localparam logic [DW-1:0] D_MAX    = DW'(N_DIGITS);
    localparam logic [EW-1:0] E_OP     = EW'(N_OPERANDS);
    localparam logic [EW-1:0] E_SHOW   = EW'(N_OPERANDS + 1);
    localparam logic [EW-1:0] E_RESET  = EW'(N_OPERANDS + 2);

    typedef enum logic [2:0] {
        ENTRY      = 3'd0,
        SEND       = 3'd1,
        OP_SELECT  = 3'd2,
        OP_LATCH   = 3'd3,
        OP_WAIT    = 3'd4,
        SHOW       = 3'd5,
        RESET_CALC = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k, k_nxt;
    logic [DW-1:0]   d, d_nxt;

    logic [N_OPERANDS-1:0] trig_nxt;
    logic [EW-1:0]         estado_nxt;
    logic [DW-1:0]         dc_nxt;
    logic                  full_nxt;

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        d_nxt     = d;
        if (clear && state != RESET_CALC) begin
            state_nxt = RESET_CALC;
        end else begin
            case (state)
                ENTRY: begin
                    if (exe) begin
                        if (k < K_LAST) begin
                            k_nxt = k + 1'b1;
                            d_nxt = '0;
                        end else begin
                            state_nxt = OP_SELECT;
                        end
                    end else if (button && d < D_MAX) begin
                        state_nxt = SEND;
                    end
                end
                SEND: begin
                    state_nxt = ENTRY;
                    d_nxt     = d + 1'b1;
                end
                OP_SELECT:  if (button) state_nxt = OP_LATCH;
                OP_LATCH:   state_nxt = OP_WAIT;
                OP_WAIT:    if (exe) state_nxt = SHOW;
                SHOW:       if (exe) state_nxt = RESET_CALC;
                RESET_CALC: begin
                    state_nxt = ENTRY;
                    k_nxt     = '0;
                    d_nxt     = '0;
                end
                default: begin
                    state_nxt = ENTRY;
                    k_nxt     = '0;
                    d_nxt     = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it, so
    // each registered output is a pure function of the current state.
    always_comb begin
        trig_nxt   = '0;
        estado_nxt = '0;
        dc_nxt     = '0;
        full_nxt   = 1'b0;
        case (state_nxt)
            ENTRY: begin
                estado_nxt = EW'(k_nxt);
                dc_nxt     = d_nxt;
                full_nxt   = (d_nxt == D_MAX);
            end
            SEND: begin
                trig_nxt[k_nxt] = 1'b1;
                estado_nxt      = EW'(k_nxt);
                dc_nxt          = d_nxt;
            end
            OP_SELECT, OP_LATCH, OP_WAIT: estado_nxt = E_OP;
            SHOW:                         estado_nxt = E_SHOW;
            RESET_CALC:                   estado_nxt = E_RESET;
            default:                      estado_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ENTRY;
            k           <= '0;
            d           <= '0;
            trigger     <= '0;
            trigger_op  <= 1'b0;
            reset_a_reg <= 1'b0;
            estado      <= '0;
            digit_count <= '0;
            full        <= 1'b0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            d           <= d_nxt;
            trigger     <= trig_nxt;
            trigger_op  <= (state_nxt == OP_LATCH);
            reset_a_reg <= (state_nxt == RESET_CALC);
            estado      <= estado_nxt;
            digit_count <= dc_nxt;
            full        <= full_nxt;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: table-driven cycle vectors at default
// parameters plus async-reset and N_OPERANDS=3/N_DIGITS=2 sequences.
module tb_calc_sequencer;

    logic clk = 1'b0;
    logic rst, exe, button, clear;

    logic [1:0] trigger;
    logic       trigger_op, reset_a_reg, full;
    logic [2:0] estado, digit_count;

    logic [2:0] t3;
    logic       top3, ra3, full3;
    logic [2:0] est3;
    logic [1:0] dc3;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    calc_sequencer dut (
        .clk(clk), .rst(rst), .exe(exe), .button(button), .clear(clear),
        .trigger(trigger), .trigger_op(trigger_op), .reset_a_reg(reset_a_reg),
        .estado(estado), .digit_count(digit_count), .full(full)
    );

    calc_sequencer #(.N_OPERANDS(3), .N_DIGITS(2)) dut3 (
        .clk(clk), .rst(rst), .exe(exe), .button(button), .clear(clear),
        .trigger(t3), .trigger_op(top3), .reset_a_reg(ra3),
        .estado(est3), .digit_count(dc3), .full(full3)
    );

    typedef struct {
        bit       e, b, c;
        bit [1:0] trig;
        bit       top, ra;
        bit [2:0] est, dc;
        bit       full;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit e, bit b, bit c, bit [1:0] trig, bit top, bit ra,
                               int est, int dc, bit f);
        vec_t r;
        r.e = e; r.b = b; r.c = c; r.trig = trig; r.top = top; r.ra = ra;
        r.est = 3'(est); r.dc = 3'(dc); r.full = f;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(bit e, bit b, bit c);
        exe = e; button = b; clear = c;
        @(posedge clk);
        #1;
        exe = 1'b0; button = 1'b0; clear = 1'b0;
    endtask

    int cnt[3];

    task automatic step3(bit e, bit b, bit c);
        step(e, b, c);
        for (int i = 0; i < 3; i++) cnt[i] += int'(t3[i]);
    endtask

    initial begin
        // e b c | trig top ra est dc full
        // full sequence
        vecs.push_back(v(0,1,0, 2'b01,0,0, 0,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,1,0));
        vecs.push_back(v(0,1,0, 2'b01,0,0, 0,1,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,2,0));
        vecs.push_back(v(0,1,0, 2'b01,0,0, 0,2,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,3,0));
        vecs.push_back(v(1,0,0, 2'b00,0,0, 1,0,0));
        vecs.push_back(v(0,1,0, 2'b10,0,0, 1,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 1,1,0));
        vecs.push_back(v(0,1,0, 2'b10,0,0, 1,1,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 1,2,0));
        vecs.push_back(v(1,0,0, 2'b00,0,0, 2,0,0));
        vecs.push_back(v(1,0,0, 2'b00,0,0, 2,0,0));
        vecs.push_back(v(0,1,0, 2'b00,1,0, 2,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 2,0,0));
        vecs.push_back(v(0,1,0, 2'b00,0,0, 2,0,0));
        vecs.push_back(v(1,0,0, 2'b00,0,0, 3,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 3,0,0));
        vecs.push_back(v(1,0,0, 2'b00,0,1, 4,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,0,0));
        // overflow: six buttons, only four strobes
        vecs.push_back(v(0,1,0, 2'b01,0,0, 0,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,1,0));
        vecs.push_back(v(0,1,0, 2'b01,0,0, 0,1,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,2,0));
        vecs.push_back(v(0,1,0, 2'b01,0,0, 0,2,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,3,0));
        vecs.push_back(v(0,1,0, 2'b01,0,0, 0,3,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,4,1));
        vecs.push_back(v(0,1,0, 2'b00,0,0, 0,4,1));
        vecs.push_back(v(0,1,0, 2'b00,0,0, 0,4,1));
        // exe and button together: exe wins
        vecs.push_back(v(1,1,0, 2'b00,0,0, 1,0,0));
        // abort from OP_WAIT
        vecs.push_back(v(1,0,0, 2'b00,0,0, 2,0,0));
        vecs.push_back(v(0,1,0, 2'b00,1,0, 2,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 2,0,0));
        vecs.push_back(v(0,0,1, 2'b00,0,1, 4,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,0,0));
        // clear overrides exe while in SEND
        vecs.push_back(v(0,1,0, 2'b01,0,0, 0,0,0));
        vecs.push_back(v(1,0,1, 2'b00,0,1, 4,0,0));
        vecs.push_back(v(0,0,0, 2'b00,0,0, 0,0,0));

        rst = 1'b1; exe = 1'b0; button = 1'b0; clear = 1'b0;
        #12;
        check("reset_outputs",
              int'({trigger, trigger_op, reset_a_reg, estado, digit_count, full}), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge_entry", int'({estado, digit_count, reset_a_reg}), 0);

        foreach (vecs[i]) begin
            step(vecs[i].e, vecs[i].b, vecs[i].c);
            total++;
            if (trigger === vecs[i].trig && trigger_op === vecs[i].top &&
                reset_a_reg === vecs[i].ra && estado === vecs[i].est &&
                digit_count === vecs[i].dc && full === vecs[i].full) begin
                pass_cnt++;
            end else begin
                $display("FAIL vec%0d: got trig=%b op=%b ra=%b est=%0d dc=%0d full=%b expected trig=%b op=%b ra=%b est=%0d dc=%0d full=%b",
                         i, trigger, trigger_op, reset_a_reg, estado, digit_count, full,
                         vecs[i].trig, vecs[i].top, vecs[i].ra, vecs[i].est, vecs[i].dc,
                         vecs[i].full);
            end
        end

        // async reset mid-SEND with k=1, d=1
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        check("pre_rst_send_trigger", int'(trigger), 2);
        #2 rst = 1'b1;
        #1;
        check("rst_trigger_async", int'(trigger), 0);
        check("rst_estado_async", int'(estado), 0);
        check("rst_digit_count_async", int'(digit_count), 0);
        @(posedge clk);
        #1;
        check("rst_no_reset_a_reg", int'({reset_a_reg, trigger_op, full}), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_estado", int'(estado), 0);
        check("post_rst_digit_count", int'(digit_count), 0);
        check("post_rst_reset_a_reg", int'(reset_a_reg), 0);

        // N_OPERANDS=3, N_DIGITS=2 sweep
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int op = 0; op < 3; op++) begin
            check($sformatf("p3_estado_op%0d", op), int'(est3), op);
            repeat (3) begin
                step3(0, 1, 0);
                step3(0, 0, 0);
            end
            check($sformatf("p3_strobes_op%0d", op), cnt[op], 2);
            check($sformatf("p3_full_op%0d", op), int'({dc3, full3}), 5);
            step3(1, 0, 0);
        end
        check("p3_total_strobes", cnt[0] + cnt[1] + cnt[2], 6);
        check("p3_estado_opsel", int'(est3), 3);
        step3(0, 1, 0);
        check("p3_trigger_op", int'({top3, est3}), 8 + 3);
        step3(0, 0, 0);
        step3(1, 0, 0);
        check("p3_estado_show", int'(est3), 4);
        step3(1, 0, 0);
        check("p3_reset_calc", int'({ra3, est3}), 8 + 5);
        step3(0, 0, 0);
        check("p3_back_to_entry", int'({ra3, est3, dc3}), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
